// File: rtl/i2s_pkg.sv
// Shared I2S constants and types for the receive and transmit paths.
package i2s_pkg;
  localparam int FRAME_HALF_PERIODS = 128;
  localparam int SLOT_BITS          = 24;
  localparam int SAMPLE_BITS        = 16;
  localparam int MIN_HALF_PERIOD    = 2;

  typedef logic signed [SAMPLE_BITS-1:0] sample_t;
  typedef logic [4:0]                    slot_t;
endpackage

// File: rtl/i2s_clk_gen.sv
// I2S master timing: 64-bclk frames, bclk = f_clk/(2*max(bclk_period,2)); tick_rise/tick_fall mark
// the last clk before bclk rises/falls. en low parks both counters at frame start on the next clk.
module i2s_clk_gen
  import i2s_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] bclk_period,
  output logic       bclk,
  output logic       lr_clk,
  output slot_t      slot,
  output logic       tick_rise,
  output logic       tick_fall
);
  localparam int HW = $clog2(FRAME_HALF_PERIODS);

  logic [7:0]    ccnt;
  logic [HW-1:0] hcnt;
  logic [7:0]    last_cnt;
  logic          tick;

  // Equality compare only: shrinking the period under a running counter lets it wrap through 255.
  assign last_cnt = (bclk_period < 8'(MIN_HALF_PERIOD)) ? 8'(MIN_HALF_PERIOD - 1)
                                                        : bclk_period - 8'd1;
  assign tick     = en && (ccnt == last_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccnt <= '0;
      hcnt <= '0;
    end else if (!en) begin
      ccnt <= '0;
      hcnt <= '0;
    end else if (tick) begin
      ccnt <= '0;
      hcnt <= hcnt + HW'(1);
    end else begin
      ccnt <= ccnt + 8'd1;
    end
  end

  assign bclk      = hcnt[0];
  assign lr_clk    = hcnt[HW-1];
  assign slot      = hcnt[HW-2:1];
  assign tick_rise = tick && !hcnt[0];
  assign tick_fall = tick && hcnt[0];
endmodule

// File: rtl/i2s_rx.sv
// I2S mic receiver, 24-bit slot -> 16-bit sample (I2S_RX_ROUND_EN: round half up + saturate, else truncate).
// sample_vld rises 1 clk after the slot-24 capture; a sample completing while one is still held is dropped with overrun.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter bit CHANNEL     = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] bclk_period,
  input  logic       sd_in,
  output logic       bclk,
  output logic       lr_clk,
  output logic       sample_vld,
  input  logic       sample_rdy,
  output sample_t    sample,
  output logic       overrun
);
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  slot_t                slot;
  logic                 tick_rise;
  logic                 tick_fall;
  logic [STAGES-1:0]    sync_q;
  logic                 sd_s;
  logic [SLOT_BITS-1:0] shift;
  logic [SLOT_BITS-1:0] word;
  logic                 our_half;
  logic                 cap;
  logic                 done;
  sample_t              conv;

  i2s_clk_gen u_clk_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .bclk_period (bclk_period),
    .bclk        (bclk),
    .lr_clk      (lr_clk),
    .slot        (slot),
    .tick_rise   (tick_rise),
    .tick_fall   (tick_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], sd_in};
  end
  assign sd_s = sync_q[STAGES-1];

  // Slot 0 carries the I2S one-bit delay; slots 1..24 hold D23..D0.
  assign our_half = (lr_clk == CHANNEL);
  assign cap      = tick_fall && our_half && (slot != '0) && (slot <= slot_t'(SLOT_BITS));
  assign done     = cap && (slot == slot_t'(SLOT_BITS));
  assign word     = {shift[SLOT_BITS-2:0], sd_s};

`ifdef I2S_RX_ROUND_EN
  logic [SAMPLE_BITS:0] rnd;
  assign rnd  = {word[SLOT_BITS-1], word[SLOT_BITS-1 -: SAMPLE_BITS]}
              + {{SAMPLE_BITS{1'b0}}, word[SLOT_BITS-SAMPLE_BITS-1]};
  // Only a positive carry into the sign bit is possible.
  assign conv = (rnd[SAMPLE_BITS] != rnd[SAMPLE_BITS-1]) ? sample_t'({1'b0, {(SAMPLE_BITS-1){1'b1}}})
                                                          : sample_t'(rnd[SAMPLE_BITS-1:0]);
`else
  assign conv = sample_t'(word[SLOT_BITS-1 -: SAMPLE_BITS]);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift <= '0;
    end else if (!en) begin
      shift <= '0;
    end else if (cap) begin
      shift <= word;
    end else if (tick_rise && our_half && (slot == '0)) begin
      shift <= '0;
    end
  end

  // Output register: a completion in the handshake cycle replaces the consumed sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_vld <= 1'b0;
      sample     <= '0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done && (!sample_vld || sample_rdy)) begin
        sample     <= conv;
        sample_vld <= 1'b1;
      end else if (done) begin
        overrun <= 1'b1;
      end else if (sample_rdy) begin
        sample_vld <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_i2s_rx.sv
// Scoreboard bench for i2s_rx: a mic model serialises queued words; a monitor checks every accepted sample.
module tb_i2s_rx;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [7:0]  bclk_period;
  logic        sd_in = 1'b0;
  logic        bclk;
  logic        lr_clk;
  logic        sample_vld;
  logic        sample_rdy;
  logic signed [15:0] sample;
  logic        overrun;

  localparam logic [23:0] LEFT_WORD = 24'hABCDEF;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int ovr_cnt = 0;
  logic [15:0] exp_q[$];
  logic [23:0] rq[$];

  i2s_rx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .bclk_period (bclk_period),
    .sd_in       (sd_in),
    .bclk        (bclk),
    .lr_clk      (lr_clk),
    .sample_vld  (sample_vld),
    .sample_rdy  (sample_rdy),
    .sample      (sample),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Mic model: new bit after each bclk fall, MSB in slot 1, words taken from rq at each right-half start.
  logic [23:0] cur_r = '0;
  logic [23:0] mword;
  logic prev_bclk = 1'b0, prev_lr = 1'b0, rise_lr = 1'b0;
  int bcnt = 0, nslot;
  always @(negedge clk) begin
    if (!prev_lr && lr_clk === 1'b1) cur_r = (rq.size() > 0) ? rq.pop_front() : 24'h0;
    if (!prev_bclk && bclk === 1'b1) begin
      if (lr_clk != rise_lr) bcnt = 0;
      else                   bcnt++;
      rise_lr = lr_clk;
    end
    if (prev_bclk && bclk === 1'b0) begin
      nslot = bcnt + 1;
      mword = lr_clk ? cur_r : LEFT_WORD;
      sd_in = (nslot >= 1 && nslot <= 24) ? mword[24 - nslot] : 1'b0;
    end
    prev_bclk = bclk;
    prev_lr   = lr_clk;
  end

  // Monitor: every handshake pops one expected sample.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && sample_vld === 1'b1 && sample_rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_sample: got %h, none expected (t=%0t)", sample, $time);
      end else begin
        check("sample", {16'h0, $unsigned(sample)}, {16'h0, exp_q.pop_front()});
      end
    end
    if (overrun === 1'b1) ovr_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic wait_rise(input bit sel_lr, output int t, output bit ok);
    logic p;
    p  = sel_lr ? lr_clk : bclk;
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (!p && (sel_lr ? lr_clk : bclk)) begin
        ok = 1'b1;
        t  = cyc;
      end
      p = sel_lr ? lr_clk : bclk;
    end
  endtask

  function automatic int frame_clk();
    return 128 * ((bclk_period < 8'd2) ? 2 : int'(bclk_period));
  endfunction

  task automatic run_frames(input int n, input bit meas_bclk, input int exp_bclk, input bit meas_lr);
    int start, t1, t2;
    bit ok1, ok2;
    step();
    en    = 1'b1;
    start = cyc;
    if (meas_bclk) begin
      wait_rise(1'b0, t1, ok1);
      wait_rise(1'b0, t2, ok2);
      check("bclk_period_clk", (ok1 && ok2) ? t2 - t1 : -1, exp_bclk);
    end
    if (meas_lr) begin
      wait_rise(1'b1, t1, ok1);
      wait_rise(1'b1, t2, ok2);
      check("frame_clk", (ok1 && ok2) ? t2 - t1 : -1, 512);
    end
    wait_until(start + n * frame_clk());
    en = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) step();
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start, ovr_base;
    rst_n = 1'b0; en = 1'b0; bclk_period = 8'd4; sample_rdy = 1'b1;
    repeat (3) step();
    check("rst_bclk", bclk, 0);
    check("rst_lr_clk", lr_clk, 0);
    check("rst_vld", sample_vld, 0);
    check("rst_sample", $unsigned(sample), 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;

    // Right channel only, one sample per frame.
    rq.push_back(24'h123456); rq.push_back(24'h123456);
    exp_q.push_back(16'h1234); exp_q.push_back(16'h1234);
    run_frames(2, 1'b1, 8, 1'b1);
    drain("right_channel_drain");

    // Back-pressure: three frames held off, two overruns.
    sample_rdy = 1'b0;
    rq.push_back(24'h111100); rq.push_back(24'h222200); rq.push_back(24'h333300);
    exp_q.push_back(16'h1111);
    ovr_base = ovr_cnt;
    run_frames(3, 1'b0, 0, 1'b0);
    repeat (5) step();
    check("bp_overruns", ovr_cnt - ovr_base, 2);
    check("bp_held_sample", $unsigned(sample), 16'h1111);
    check("bp_held_vld", sample_vld, 1);
    sample_rdy = 1'b1;
    drain("bp_accept");
    rq.push_back(24'h444400);
    exp_q.push_back(16'h4444);
    run_frames(1, 1'b0, 0, 1'b0);
    drain("bp_next_sample");

    // Handshake in the exact completion cycle (capture tick of hcnt 113 = clk 455 of the frame).
    sample_rdy = 1'b0;
    rq.push_back(24'h555500); rq.push_back(24'h666600);
    exp_q.push_back(16'h5555); exp_q.push_back(16'h6666);
    run_frames(1, 1'b0, 0, 1'b0);
    ovr_base = ovr_cnt;
    step();
    en = 1'b1;
    start = cyc;
    wait_until(start + 455);
    sample_rdy = 1'b1;
    step();
    sample_rdy = 1'b0;
    check("simul_vld", sample_vld, 1);
    check("simul_sample", $unsigned(sample), 16'h6666);
    wait_until(start + 512);
    en = 1'b0;
    check("simul_overrun", ovr_cnt - ovr_base, 0);
    sample_rdy = 1'b1;
    drain("simul_drain");

    // Period clamp: 0 and 1 both give a 4-clk bclk.
    bclk_period = 8'd0;
    rq.push_back(24'h123456); exp_q.push_back(16'h1234);
    run_frames(1, 1'b1, 4, 1'b0);
    bclk_period = 8'd1;
    rq.push_back(24'h2468AC); exp_q.push_back(16'h2468);
    run_frames(1, 1'b1, 4, 1'b0);
    drain("clamp_drain");

    // en dropped at slot 12 of the right half (hcnt 89, bclk high).
    bclk_period = 8'd4;
    rq.push_back(24'h777700);
    step();
    en = 1'b1;
    start = cyc;
    wait_until(start + 357);
    check("pre_drop_bclk", bclk, 1);
    check("pre_drop_lr", lr_clk, 1);
    en = 1'b0;
    step();
    check("drop_bclk", bclk, 0);
    check("drop_lr", lr_clk, 0);
    repeat (600) step();
    check("drop_no_sample", sample_vld, 0);
    rq.push_back(24'h123456); exp_q.push_back(16'h1234);
    run_frames(1, 1'b0, 0, 1'b0);
    drain("reenable_drain");

    // 24->16 conversion boundaries.
    rq.push_back(24'h12347F); rq.push_back(24'h123480);
    rq.push_back(24'h7FFF80); rq.push_back(24'hFFFF80);
`ifdef I2S_RX_ROUND_EN
    exp_q.push_back(16'h1234); exp_q.push_back(16'h1235);
    exp_q.push_back(16'h7FFF); exp_q.push_back(16'h0000);
`else
    exp_q.push_back(16'h1234); exp_q.push_back(16'h1234);
    exp_q.push_back(16'h7FFF); exp_q.push_back(16'hFFFF);
`endif
    run_frames(4, 1'b0, 0, 1'b0);
    drain("conv_drain");

    // Async reset at slot 10 of the right half, with a sample held.
    sample_rdy = 1'b0;
    rq.push_back(24'h999900);
    run_frames(1, 1'b0, 0, 1'b0);
    rq.push_back(24'h888800);
    step();
    en = 1'b1;
    start = cyc;
    wait_until(start + 338);
    check("pre_rst_vld", sample_vld, 1);
    rst_n = 1'b0;
    #1;
    check("arst_bclk", bclk, 0);
    check("arst_lr_clk", lr_clk, 0);
    check("arst_vld", sample_vld, 0);
    check("arst_sample", $unsigned(sample), 0);
    check("arst_overrun", overrun, 0);
    step();
    rst_n = 1'b1;
    sample_rdy = 1'b1;
    rq.push_back(24'hFEDC12); exp_q.push_back(16'hFEDC);
    run_frames(1, 1'b0, 0, 1'b0);
    drain("post_rst_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
